rv32i_ctrl_fsm: RTL and testbench

- Multi-cycle RV32I control unit that sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Sits directly upstream of the immediate generator. Decodes the opcode held in the instruction register and drives the generator's 3-bit immediate-select, plus all datapath strobes (PC, IR, register file, data memory, ALU operand muxes).

---
 rtl/rv32i_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm: multi-cycle RV32I control unit.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes plus the immediate generator's select code.
module rv32i_ctrl_fsm #(
  parameter logic [2:0] IMMSEL_NONE    = 3'd5,
  parameter bit         HALT_ON_SYSTEM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  immsel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t     state_q;
  state_t     state_d;
  logic [6:0] opcode;

  logic       known_op;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_jump;
  logic       is_fence;
  logic       is_system;
  logic [2:0] imm_dec;
  logic [1:0] a_dec;
  logic       b_dec;
  logic [1:0] wb_dec;

  assign opcode = instr[6:0];
  assign state  = state_q;

  // Opcode classification: immediate type, operand selects and writeback source
  always_comb begin
    known_op  = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_fence  = 1'b0;
    is_system = 1'b0;
    imm_dec   = IMMSEL_NONE;
    a_dec     = 2'd0;
    b_dec     = 1'b1;
    wb_dec    = 2'd0;
    case (opcode)
      OPC_LUI:    begin imm_dec = 3'd0; a_dec = 2'd2; end
      OPC_AUIPC:  begin imm_dec = 3'd0; a_dec = 2'd1; end
      OPC_JAL:    begin imm_dec = 3'd1; a_dec = 2'd1; is_jump = 1'b1; wb_dec = 2'd2; end
      OPC_JALR:   begin imm_dec = 3'd2; is_jump = 1'b1; wb_dec = 2'd2; end
      OPC_LOAD:   begin imm_dec = 3'd2; is_load = 1'b1; wb_dec = 2'd1; end
      OPC_OPIMM:  begin imm_dec = 3'd2; end
      OPC_BRANCH: begin imm_dec = 3'd3; a_dec = 2'd1; is_branch = 1'b1; end
      OPC_STORE:  begin imm_dec = 3'd4; is_store = 1'b1; end
      OPC_OP:     begin b_dec = 1'b0; end
      OPC_FENCE:  begin is_fence = 1'b1; end
      OPC_SYSTEM: begin is_system = 1'b1; end
      default:    begin known_op = 1'b0; end
    endcase
  end

  // State register; reset returns to FETCH from anywhere, dropping any pending request
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; everything held at idle values while reset is high
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    immsel    = IMMSEL_NONE;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          immsel = imm_dec;
          if (!known_op || (is_system && HALT_ON_SYSTEM))
            state_d = S_HALT;
          else if (is_fence || is_system)
            state_d = S_FETCH;
          else
            state_d = S_EXEC;
        end
        S_EXEC: begin
          immsel    = imm_dec;
          alu_a_sel = a_dec;
          alu_b_sel = b_dec;
          if (is_jump) begin
            pc_we  = 1'b1;
            pc_sel = 1'b1;
          end else if (is_branch) begin
            pc_we  = branch_taken;
            pc_sel = 1'b1;
          end
          if (is_load || is_store) state_d = S_MEM;
          else if (is_branch)      state_d = S_FETCH;
          else                     state_d = S_WB;
        end
        S_MEM: begin
          immsel    = imm_dec;
          alu_a_sel = a_dec;
          alu_b_sel = b_dec;
          dmem_req  = 1'b1;
          dmem_we   = is_store;
          if (dmem_ready) state_d = is_load ? S_WB : S_FETCH;
        end
        S_WB: begin
          immsel    = imm_dec;
          alu_a_sel = a_dec;
          alu_b_sel = b_dec;
          rf_we     = 1'b1;
          wb_sel    = wb_dec;
          state_d   = S_FETCH;
        end
        S_HALT: begin
          halted  = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// tb_rv32i_ctrl_fsm: cycle-by-cycle vector bench for the RV32I control FSM.
module tb_rv32i_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic [2:0]  immsel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_LW    = 32'h00002083;
  localparam logic [31:0] I_SW    = 32'h00112023;
  localparam logic [31:0] I_BEQ   = 32'h00000463;
  localparam logic [31:0] I_FENCE = 32'h0000000F;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  // Expected view of one cycle: state followed by every output
  typedef struct packed {
    logic [2:0] st;
    logic       ireq;
    logic       irwe;
    logic       pcwe;
    logic       pcsel;
    logic [2:0] imm;
    logic [1:0] a;
    logic       b;
    logic       dreq;
    logic       dwe;
    logic       rfwe;
    logic [1:0] wb;
    logic       h;
  } outs_t;

  typedef struct {
    string       name;
    logic        r;
    logic [31:0] i;
    logic        ir;
    logic        dr;
    logic        bt;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];

  rv32i_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .immsel(immsel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
    .wb_sel(wb_sel), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  function automatic outs_t o(input logic [2:0] st, input logic ireq, input logic irwe,
                              input logic pcwe, input logic pcsel, input logic [2:0] imm,
                              input logic [1:0] a, input logic b, input logic dreq,
                              input logic dwe, input logic rfwe, input logic [1:0] wb,
                              input logic h);
    outs_t r;
    r = '{st, ireq, irwe, pcwe, pcsel, imm, a, b, dreq, dwe, rfwe, wb, h};
    return r;
  endfunction

  function automatic vec_t mk(input string n, input logic r, input logic [31:0] i,
                              input logic ir, input logic dr, input logic bt, input outs_t e);
    vec_t v;
    v.name = n; v.r = r; v.i = i; v.ir = ir; v.dr = dr; v.bt = bt; v.exp = e;
    return v;
  endfunction

  // Common expectations
  function automatic outs_t idle(input logic [2:0] st);
    return o(st, 0, 0, 0, 0, 3'd5, 2'd0, 0, 0, 0, 0, 2'd0, 0);
  endfunction

  function automatic outs_t fetch_hit();
    return o(3'd0, 1, 1, 1, 0, 3'd5, 2'd0, 0, 0, 0, 0, 2'd0, 0);
  endfunction

  function automatic outs_t fetch_wait();
    return o(3'd0, 1, 0, 0, 0, 3'd5, 2'd0, 0, 0, 0, 0, 2'd0, 0);
  endfunction

  function automatic outs_t dec(input logic [2:0] imm);
    return o(3'd1, 0, 0, 0, 0, imm, 2'd0, 0, 0, 0, 0, 2'd0, 0);
  endfunction

  function automatic outs_t halt_o();
    return o(3'd5, 0, 0, 0, 0, 3'd5, 2'd0, 0, 0, 0, 0, 2'd0, 1);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst          = v.r;
    instr        = v.i;
    imem_ready   = v.ir;
    dmem_ready   = v.dr;
    branch_taken = v.bt;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    outs_t got;
    got = '{state, imem_req, ir_we, pc_we, pc_sel, immsel, alu_a_sel, alu_b_sel,
            dmem_req, dmem_we, rf_we, wb_sel, halted};
    checks++;
    if (got !== v.exp) begin
      failures++;
      $display("[TB] FAIL step%0d %s got=%b want=%b (st,ireq,irwe,pcwe,pcsel,imm,a,b,dreq,dwe,rfwe,wb,h)",
               idx, v.name, got, v.exp);
    end
  endtask

  task automatic runVec(input int idx, input vec_t v);
    #1 applyStimulus(v);
    #3 checkOutput(idx, v);
    @(posedge clk);
  endtask

  initial begin
    // Reset and LUI
    vecs.push_back(mk("rst_idle",   1, 32'h0, 0, 0, 0, idle(3'd0)));
    vecs.push_back(mk("lui_fetch",  0, I_LUI, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("lui_dec",    0, I_LUI, 1, 1, 0, dec(3'd0)));
    vecs.push_back(mk("lui_exec",   0, I_LUI, 1, 1, 0, o(3'd2,0,0,0,0,3'd0,2'd2,1,0,0,0,2'd0,0)));
    vecs.push_back(mk("lui_wb",     0, I_LUI, 0, 0, 0, o(3'd4,0,0,0,0,3'd0,2'd2,1,0,0,1,2'd0,0)));
    // LW with three memory wait cycles
    vecs.push_back(mk("lw_fetch",   0, I_LW, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("lw_dec",     0, I_LW, 0, 0, 0, dec(3'd2)));
    vecs.push_back(mk("lw_exec",    0, I_LW, 0, 1, 0, o(3'd2,0,0,0,0,3'd2,2'd0,1,0,0,0,2'd0,0)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("lw_memwait", 0, I_LW, 1, 0, 0, o(3'd3,0,0,0,0,3'd2,2'd0,1,1,0,0,2'd0,0)));
    vecs.push_back(mk("lw_memdone", 0, I_LW, 0, 1, 0, o(3'd3,0,0,0,0,3'd2,2'd0,1,1,0,0,2'd0,0)));
    vecs.push_back(mk("lw_wb",      0, I_LW, 0, 0, 0, o(3'd4,0,0,0,0,3'd2,2'd0,1,0,0,1,2'd1,0)));
    // SW, then one FETCH wait cycle
    vecs.push_back(mk("sw_fetch",   0, I_SW, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("sw_dec",     0, I_SW, 0, 0, 0, dec(3'd4)));
    vecs.push_back(mk("sw_exec",    0, I_SW, 0, 0, 0, o(3'd2,0,0,0,0,3'd4,2'd0,1,0,0,0,2'd0,0)));
    vecs.push_back(mk("sw_mem",     0, I_SW, 0, 1, 0, o(3'd3,0,0,0,0,3'd4,2'd0,1,1,1,0,2'd0,0)));
    vecs.push_back(mk("fetch_wait", 0, I_SW, 0, 1, 0, fetch_wait()));
    // BEQ not taken then taken
    vecs.push_back(mk("beq_fetch0", 0, I_BEQ, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("beq_dec0",   0, I_BEQ, 0, 0, 1, dec(3'd3)));
    vecs.push_back(mk("beq_nt",     0, I_BEQ, 0, 0, 0, o(3'd2,0,0,0,1,3'd3,2'd1,1,0,0,0,2'd0,0)));
    vecs.push_back(mk("beq_fetch1", 0, I_BEQ, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("beq_dec1",   0, I_BEQ, 0, 0, 0, dec(3'd3)));
    vecs.push_back(mk("beq_tk",     0, I_BEQ, 0, 0, 1, o(3'd2,0,0,1,1,3'd3,2'd1,1,0,0,0,2'd0,0)));
    // FENCE returns to FETCH straight from DECODE
    vecs.push_back(mk("fence_fetch",0, I_FENCE, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("fence_dec",  0, I_FENCE, 0, 0, 0, dec(3'd5)));
    // JALR
    vecs.push_back(mk("jalr_fetch", 0, I_JALR, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("jalr_dec",   0, I_JALR, 0, 0, 0, dec(3'd2)));
    vecs.push_back(mk("jalr_exec",  0, I_JALR, 0, 0, 0, o(3'd2,0,0,1,1,3'd2,2'd0,1,0,0,0,2'd0,0)));
    vecs.push_back(mk("jalr_wb",    0, I_JALR, 0, 0, 0, o(3'd4,0,0,0,0,3'd2,2'd0,1,0,0,1,2'd2,0)));
    // OP (register-register add)
    vecs.push_back(mk("add_fetch",  0, I_ADD, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("add_dec",    0, I_ADD, 0, 0, 0, dec(3'd5)));
    vecs.push_back(mk("add_exec",   0, I_ADD, 0, 0, 0, o(3'd2,0,0,0,0,3'd5,2'd0,0,0,0,0,2'd0,0)));
    vecs.push_back(mk("add_wb",     0, I_ADD, 0, 0, 0, o(3'd4,0,0,0,0,3'd5,2'd0,0,0,0,1,2'd0,0)));
    // JAL
    vecs.push_back(mk("jal_fetch",  0, I_JAL, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("jal_dec",    0, I_JAL, 0, 0, 0, dec(3'd1)));
    vecs.push_back(mk("jal_exec",   0, I_JAL, 0, 0, 0, o(3'd2,0,0,1,1,3'd1,2'd1,1,0,0,0,2'd0,0)));
    vecs.push_back(mk("jal_wb",     0, I_JAL, 0, 0, 0, o(3'd4,0,0,0,0,3'd1,2'd1,1,0,0,1,2'd2,0)));
    // Illegal opcode halts; HALT ignores imem_ready
    vecs.push_back(mk("ill_fetch",  0, I_ILL, 1, 0, 0, fetch_hit()));
    vecs.push_back(mk("ill_dec",    0, I_ILL, 1, 1, 0, dec(3'd5)));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk("halt_hold", 0, I_ILL, 1, 1, 0, halt_o()));

    rst = 1'b1; instr = '0; imem_ready = 0; dmem_ready = 0; branch_taken = 0;
    @(posedge clk);
    for (int n = 0; n < vecs.size(); n++)
      runVec(n, vecs[n]);

    // Hand sequence: leave HALT by reset, then reset mid-MEM and with a
    // simultaneous imem_ready, then ECALL halts
    runVec(100, mk("rst_in_halt",   1, I_ILL, 1, 0, 0, idle(3'd5)));
    runVec(101, mk("lw2_fetch",     0, I_LW, 1, 0, 0, fetch_hit()));
    runVec(102, mk("lw2_dec",       0, I_LW, 0, 0, 0, dec(3'd2)));
    runVec(103, mk("lw2_exec",      0, I_LW, 0, 0, 0, o(3'd2,0,0,0,0,3'd2,2'd0,1,0,0,0,2'd0,0)));
    runVec(104, mk("lw2_memwait",   0, I_LW, 0, 0, 0, o(3'd3,0,0,0,0,3'd2,2'd0,1,1,0,0,2'd0,0)));
    runVec(105, mk("rst_in_mem",    1, I_LW, 0, 0, 0, idle(3'd3)));
    runVec(106, mk("post_rst_fetch",0, I_LW, 0, 1, 0, fetch_wait()));
    runVec(107, mk("rst_vs_ready",  1, I_ECALL, 1, 0, 0, idle(3'd0)));
    runVec(108, mk("ecall_fetch",   0, I_ECALL, 1, 0, 0, fetch_hit()));
    runVec(109, mk("ecall_dec",     0, I_ECALL, 0, 0, 0, dec(3'd5)));
    runVec(110, mk("ecall_halt",    0, I_ECALL, 1, 1, 0, halt_o()));
    runVec(111, mk("ecall_halt2",   0, I_ECALL, 1, 1, 0, halt_o()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
